// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parameterised UART receiver with held-word handshake and error flags
module uart_rx_param #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 32,
    parameter int PARITY_MODE  = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 ack,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam logic [15:0] LAST_CNT  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] MID_CNT   = 16'(CLKS_PER_BIT / 2);
    localparam logic [3:0]  LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t               state, state_nxt;
    logic                 rx_meta, rxs;
    logic [1:0]           warm;
    logic                 armed;
    logic [15:0]          cnt;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit, stop_done, stop_low, stop_high;
    logic                 bit_tick, mid_tick, complete, is_break, par_calc, par_err_calc;

    // armed only rises once the synchronizer holds real line samples showing idle,
    // so a line already low when reset releases never starts a frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            warm    <= 2'b00;
            armed   <= 1'b0;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            warm    <= {warm[0], 1'b1};
            if (warm[1] && rxs) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (armed && !rxs) state_nxt = S_START;
            S_START:  if (mid_tick) state_nxt = rxs ? S_IDLE : S_DATA;
            S_DATA:   if (bit_tick && bit_idx == LAST_DATA)
                          state_nxt = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (bit_tick) state_nxt = S_STOP;
            S_STOP:   if (stop_done) state_nxt = is_break ? S_BREAK : S_IDLE;
            S_BREAK:  if (rxs) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy         = (state != S_IDLE);
        bit_tick     = (cnt == LAST_CNT);
        mid_tick     = (cnt == MID_CNT);
        complete     = (state == S_STOP) && stop_done;
        is_break     = (shift == '0) && !stop_high;
        par_calc     = (PARITY_MODE == 2) ? ~^shift : ^shift;
        par_err_calc = (PARITY_MODE != 0) && (par_bit != par_calc);
    end

    // counter restarts at the start-bit centre so each later tick lands mid-bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            par_bit   <= 1'b0;
            stop_done <= 1'b0;
            stop_low  <= 1'b0;
            stop_high <= 1'b0;
        end else begin
            case (state)
                S_START: begin
                    cnt       <= mid_tick ? '0 : cnt + 16'd1;
                    bit_idx   <= '0;
                    stop_low  <= 1'b0;
                    stop_high <= 1'b0;
                end
                S_DATA: begin
                    cnt <= bit_tick ? '0 : cnt + 16'd1;
                    if (bit_tick) begin
                        shift   <= {rxs, shift[DATA_BITS-1:1]};
                        bit_idx <= (bit_idx == LAST_DATA) ? '0 : bit_idx + 4'd1;
                    end
                end
                S_PARITY: begin
                    cnt <= bit_tick ? '0 : cnt + 16'd1;
                    if (bit_tick) begin
                        par_bit <= rxs;
                    end
                end
                S_STOP: begin
                    cnt <= bit_tick ? '0 : cnt + 16'd1;
                    if (stop_done) begin
                        stop_done <= 1'b0;
                    end else if (bit_tick) begin
                        bit_idx <= bit_idx + 4'd1;
                        if (rxs) stop_high <= 1'b1;
                        else     stop_low  <= 1'b1;
                        if (bit_idx == LAST_STOP) stop_done <= 1'b1;
                    end
                end
                default: begin
                    cnt       <= '0;
                    stop_done <= 1'b0;
                end
            endcase
        end
    end

    // a completing frame loses to an unacknowledged held word and only marks overrun
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (complete) begin
            if (!valid || ack) begin
                data       <= shift;
                parity_err <= par_err_calc;
                frame_err  <= stop_low;
                valid      <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (ack && valid) begin
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end
    end
endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter DATA_BITS, default 8: data bits per frame, legal 5..9.
REQ-002 Parameter CLKS_PER_BIT, default 32: clk cycles per UART bit, legal 8..65535.
REQ-003 Parameter PARITY_MODE, default 1: 0 = none, 1 = even (parity bit = XOR of data bits), 2 = odd.
REQ-004 Parameter STOP_BITS, default 1: stop bits per frame, legal 1 or 2.
REQ-005 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-low reset.
REQ-007 Port rx, input, 1: serial line, idle high, asynchronous to clk.
REQ-008 Port ack, input, 1: consumer acknowledges the held word.
REQ-009 Port data, output, DATA_BITS: last accepted word, LSB received first.
REQ-010 Port valid, output, 1: data holds an unacknowledged word.
REQ-011 Port parity_err, output, 1: parity mismatch on the held word; held low when PARITY_MODE = 0.
REQ-012 Port frame_err, output, 1: a stop bit sampled low on the held word.
REQ-013 Port overrun, output, 1: sticky; a frame completed while valid = 1 and ack = 0.
REQ-014 Port busy, output, 1: FSM not in IDLE.

Function
REQ-015 rx passes through a 2-flop synchronizer; all sampling uses the synchronized value rxs.
REQ-016 FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-017 Bit counter runs 0..CLKS_PER_BIT-1; the mid-bit sample point is count = CLKS_PER_BIT/2 (integer divide).
REQ-018 IDLE -> START on the first cycle with rxs = 0; the counter clears.
REQ-019 START: at mid-bit, rxs = 1 returns to IDLE with no output change (glitch reject); rxs = 0 realigns the counter so later samples fall at bit centres, then goes to DATA.
REQ-020 DATA: samples DATA_BITS bits, one per CLKS_PER_BIT cycles, shifted in LSB first.
REQ-021 DATA then goes to PARITY if PARITY_MODE != 0, otherwise to STOP.
REQ-022 PARITY: one sample, compared against the parity computed over the received data bits.
REQ-023 STOP: STOP_BITS samples; any stop sample of 0 marks a frame error.
REQ-024 Completion occurs one cycle after the final stop sample.
REQ-025 At completion, if the data bits and stop bits were all 0, the FSM goes to BREAK. Otherwise it goes to IDLE, so back-to-back frames are accepted with no gap beyond the half stop bit.
REQ-026 BREAK: waits for rxs = 1, then goes to IDLE.
REQ-027 Completion with valid = 0, or with valid = 1 and ack = 1 in the same cycle: data, parity_err and frame_err load; valid = 1 from the next cycle; overrun unchanged.
REQ-028 Completion with valid = 1 and ack = 0: data and error flags keep the old word; overrun sets; the new frame is discarded.
REQ-029 ack with valid = 1 and no completion in that cycle: valid, parity_err, frame_err and overrun all clear the next cycle.
REQ-030 ack with valid = 0 has no effect.
REQ-031 A break frame is reported like any frame: data = 0, frame_err = 1.
REQ-032 Output latency from the rx edge is 2 cycles of synchronizer plus the bit timing; outputs are registered, with no combinational path from rx or ack.

Reset
REQ-033 rst low forces: FSM = IDLE, counters = 0, data = 0, valid = 0, parity_err = 0, frame_err = 0, overrun = 0, busy = 0, synchronizer flops = 1.
REQ-034 Reset mid-frame aborts the frame with no valid pulse.
REQ-035 After release, the block waits for rxs = 1 and then a new falling edge, so it never starts on a line already held low.

Verification
REQ-036 Defaults, 10 ns clk: send 0xD2 with even parity 0 and stop 1 at 320 ns/bit, then 0xE1 10 ns later -> data = 0xD2, valid = 1, no error flags; after ack, data = 0xE1, valid = 1.
REQ-037 Send 0xD2 with parity bit 1 -> valid = 1, parity_err = 1, frame_err = 0, data = 0xD2.
REQ-038 Send 0x55 with stop bit 0 -> frame_err = 1. Then hold rx low for 12 bit times -> second completion with data = 0x00 and frame_err = 1 (ack between the two); busy stays high until rx returns to 1.
REQ-039 rx low for 8 cycles then high -> FSM back to IDLE; valid stays 0; busy drops within CLKS_PER_BIT/2 + 3 cycles.
REQ-040 Two frames 0x11 then 0x22 with no ack -> data = 0x11, overrun = 1. Ack -> all flags clear. Ack asserted exactly at the second completion -> data = 0x22, overrun = 0.
REQ-041 Assert rst mid-DATA of a frame with PARITY_MODE = 2, DATA_BITS = 7, STOP_BITS = 2 -> no valid. Then 0x3A (odd parity 1) -> data = 0x3A, valid = 1, no errors.
